// File: rtl/cdf_write_arbiter.sv
// rtl/cdf_write_arbiter.sv - round-robin packet arbiter for the shared memory write port
module cdf_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  input  logic                      mem_ready,
  output logic [DATA_W-1:0]         WriteBus,
  output logic [ADDR_W-1:0]         WriteAddress,
  output logic                      WriteEnable,
  output logic                      busy
);

  localparam int OW = (NUM_REQ > 2) ? 2 : 1;
  localparam int CW = OW + 1;
  typedef logic [OW-1:0] idx_t;
  typedef logic [CW-1:0] cand_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_REQ - 1);
  localparam idx_t ONE_IDX  = idx_t'(1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t state, state_nxt;
  idx_t   owner, owner_nxt;
  idx_t   rr_ptr, rr_ptr_nxt;
  idx_t   pick;
  idx_t   out_owner;
  cand_t  cand;
  logic   found;
  logic   out_free;
  logic   accept;
  logic   out_last;

  // Output slot can take a new beat when empty or draining this cycle
  assign out_free = !WriteEnable || mem_ready;
  assign accept   = (state == LOCKED) && out_free && req_valid[owner];
  assign busy     = (state != IDLE) || WriteEnable;

  // First valid requester at or after rr_ptr, wrapping around
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = cand_t'(rr_ptr) + cand_t'(k);
      if (cand >= cand_t'(NUM_REQ)) cand = cand - cand_t'(NUM_REQ);
      if (!found && req_valid[cand]) begin
        pick  = cand[OW-1:0];
        found = 1'b1;
      end
    end
  end

  // Grant state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Grant a whole packet in IDLE; release the lock after its last beat is taken
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_nxt = LOCKED;
          owner_nxt = pick;
        end
      end
      LOCKED: begin
        if (accept && req_last[owner]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = (owner == LAST_IDX) ? '0 : owner + ONE_IDX;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only the locked owner sees ready, and only when the output slot is free
  always_comb begin
    req_ready = '0;
    if (state == LOCKED) req_ready[owner] = out_free;
  end

  // Write port register: hold on stall, load an accepted beat, else clear
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      WriteEnable  <= 1'b0;
      WriteBus     <= '0;
      WriteAddress <= '0;
      out_last     <= 1'b0;
      out_owner    <= '0;
    end else if (WriteEnable && !mem_ready) begin
      WriteEnable  <= WriteEnable;
    end else if (accept) begin
      WriteEnable  <= 1'b1;
      WriteBus     <= req_data[owner*DATA_W +: DATA_W];
      WriteAddress <= req_addr[owner*ADDR_W +: ADDR_W];
      out_last     <= req_last[owner];
      out_owner    <= owner;
    end else begin
      WriteEnable  <= 1'b0;
      WriteBus     <= '0;
      WriteAddress <= '0;
    end
  end

  // Done pulse once memory consumes the final beat of a packet
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      req_done <= '0;
    end else begin
      req_done <= '0;
      if (WriteEnable && mem_ready && out_last) req_done[out_owner] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cdf_write_arbiter.sv
// tb/tb_cdf_write_arbiter.sv - directed self-checking bench for cdf_write_arbiter
module tb_cdf_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 16;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic                      mem_ready;
  logic [DATA_W-1:0]         WriteBus;
  logic [ADDR_W-1:0]         WriteAddress;
  logic                      WriteEnable;
  logic                      busy;

  always #5 clock = ~clock;

  cdf_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_addr(req_addr), .req_ready(req_ready), .req_done(req_done),
    .mem_ready(mem_ready), .WriteBus(WriteBus), .WriteAddress(WriteAddress),
    .WriteEnable(WriteEnable), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Requester packet sources
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  // Behavioural model: packet lock, round-robin pointer, one output slot
  bit                 m_locked;
  int                 m_owner;
  int                 m_ptr;
  bit                 m_we;
  logic [DATA_W-1:0]  m_bus;
  logic [ADDR_W-1:0]  m_addr;
  bit                 m_last;
  int                 m_oown;
  logic [NUM_REQ-1:0] m_done;
  logic [NUM_REQ-1:0] m_ready;
  logic [NUM_REQ-1:0] m_acc;
  logic [NUM_REQ-1:0] acc_flag;
  int                 m_pick;

  always_comb begin
    m_ready = '0;
    if (m_locked && (!m_we || mem_ready)) m_ready[m_owner] = 1'b1;
    m_acc  = m_ready & req_valid;
    m_pick = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[(m_ptr + k) % NUM_REQ]) m_pick = (m_ptr + k) % NUM_REQ;
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      m_locked <= 0; m_owner <= 0; m_ptr <= 0; m_we <= 0;
      m_bus <= '0; m_addr <= '0; m_last <= 0; m_oown <= 0;
      m_done <= '0; acc_flag <= '0;
    end else begin
      acc_flag <= m_acc;
      for (int i = 0; i < NUM_REQ; i++) m_done[i] <= m_we && mem_ready && m_last && (m_oown == i);
      if (m_we && !mem_ready) begin
        m_we <= m_we;
      end else if (|m_acc) begin
        m_we   <= 1;
        m_bus  <= req_data[m_owner*DATA_W +: DATA_W];
        m_addr <= req_addr[m_owner*ADDR_W +: ADDR_W];
        m_last <= req_last[m_owner];
        m_oown <= m_owner;
      end else begin
        m_we <= 0; m_bus <= '0; m_addr <= '0;
      end
      if (!m_locked) begin
        if (|req_valid) begin
          m_locked <= 1;
          m_owner  <= m_pick;
        end
      end else if ((|m_acc) && req_last[m_owner]) begin
        m_locked <= 0;
        m_ptr    <= (m_owner + 1) % NUM_REQ;
      end
    end
  end

  // Per-cycle compare against the model, plus write and done logs
  int               cyc = 0;
  logic [15:0]      wlog[$];
  int               wstamp[$];
  int               dwho[$];
  int               dstamp[$];

  always @(negedge clock) begin
    chk("WriteEnable", 128'(WriteEnable), 128'(m_we));
    chk("WriteBus", WriteBus, m_bus);
    chk("WriteAddress", 128'(WriteAddress), 128'(m_addr));
    chk("req_ready", 128'(req_ready), 128'(m_ready));
    chk("req_done", 128'(req_done), 128'(m_done));
    chk("busy", 128'(busy), 128'(m_locked || m_we));
    if (WriteEnable && mem_ready) begin
      wlog.push_back(WriteAddress);
      wstamp.push_back(cyc);
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (req_done[i]) begin
        dwho.push_back(i);
        dstamp.push_back(cyc);
      end
    cyc <= cyc + 1;
  end

  // Stimulus helpers
  task automatic push_pkt(input int who, input logic [15:0] a0, input logic [127:0] d0, input int n);
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.addr = a0 + 16'(i);
      b.data = d0 + 128'(i);
      b.last = (i == n - 1);
      if (who == 0) q0.push_back(b);
      else q1.push_back(b);
    end
  endtask

  task automatic apply();
    req_valid = '0; req_last = '0; req_data = '0; req_addr = '0;
    if (q0.size() > 0) begin
      req_valid[0] = 1'b1; req_last[0] = q0[0].last;
      req_data[0*DATA_W +: DATA_W] = q0[0].data; req_addr[0*ADDR_W +: ADDR_W] = q0[0].addr;
    end
    if (q1.size() > 0) begin
      req_valid[1] = 1'b1; req_last[1] = q1[0].last;
      req_data[1*DATA_W +: DATA_W] = q1[0].data; req_addr[1*ADDR_W +: ADDR_W] = q1[0].addr;
    end
  endtask

  task automatic step();
    beat_t tmp;
    @(posedge clock);
    #2;
    if (acc_flag[0]) tmp = q0.pop_front();
    if (acc_flag[1]) tmp = q1.pop_front();
    apply();
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_we || m_locked) && n < 300) begin
      step();
      n++;
    end
    chk("drain_bound", 128'(n < 300), 128'(1));
    step();
    step();
  endtask

  task automatic wait_addr(input string name, input logic [15:0] a);
    int n = 0;
    while (!(m_we && m_addr == a) && n < 100) begin
      step();
      n++;
    end
    chk(name, 128'(n < 100), 128'(1));
  endtask

  logic [15:0] exp_q[$];

  task automatic check_order(input string name, input int base);
    chk({name, "_count"}, 128'(wlog.size() - base), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < wlog.size())
        chk($sformatf("%s_addr%0d", name, i), 128'(wlog[base + i]), 128'(exp_q[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    int db;
    int c0;
    int c1;

    // Reset with both requesters valid
    reset_n = 1'b0;
    mem_ready = 1'b1;
    push_pkt(0, 16'h0010, 128'hA0, 4);
    push_pkt(1, 16'h0100, 128'hB0, 1);
    apply();
    step();
    step();
    chk("reset_WriteEnable", 128'(WriteEnable), 128'(0));
    chk("reset_WriteBus", WriteBus, 128'(0));
    chk("reset_req_ready", 128'(req_ready), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));

    // Burst from req0 then req1's single beat
    b = wlog.size();
    db = dwho.size();
    reset_n = 1'b1;
    drain();
    exp_q = '{16'h0010, 16'h0011, 16'h0012, 16'h0013, 16'h0100};
    check_order("burst", b);
    if (wlog.size() >= b + 5) begin
      for (int i = 1; i < 4; i++)
        chk($sformatf("burst_consec%0d", i), 128'(wstamp[b + i]), 128'(wstamp[b] + i));
      chk("burst_gap", 128'(wstamp[b + 4]), 128'(wstamp[b + 3] + 2));
    end
    chk("burst_done_count", 128'(dwho.size() - db), 128'(2));
    if (dwho.size() >= db + 2) begin
      chk("burst_done_who", 128'(dwho[db]), 128'(0));
      if (wlog.size() >= b + 4) chk("burst_done_time", 128'(dstamp[db]), 128'(wstamp[b + 3] + 1));
      chk("burst_done1_who", 128'(dwho[db + 1]), 128'(1));
    end

    // Round robin between two competing 2-beat streams
    b = wlog.size();
    push_pkt(0, 16'h0200, 128'h20, 2);
    push_pkt(0, 16'h0202, 128'h22, 2);
    push_pkt(1, 16'h0300, 128'h30, 2);
    push_pkt(1, 16'h0302, 128'h32, 2);
    apply();
    drain();
    exp_q = '{16'h0200, 16'h0201, 16'h0300, 16'h0301, 16'h0202, 16'h0203, 16'h0302, 16'h0303};
    check_order("rr", b);
    if (wlog.size() >= b + 8) chk("rr_span", 128'(wstamp[b + 7] - wstamp[b]), 128'(10));

    // Memory back-pressure on beat 2 of a 3-beat packet
    b = wlog.size();
    push_pkt(0, 16'h0400, 128'hC0, 3);
    apply();
    wait_addr("bp_wait", 16'h0401);
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b0;
      #1;
      chk($sformatf("bp_hold_addr%0d", k), 128'(WriteAddress), 128'(16'h0401));
      chk($sformatf("bp_hold_data%0d", k), WriteBus, 128'hC1);
      chk($sformatf("bp_ready%0d", k), 128'(req_ready), 128'(0));
      step();
    end
    mem_ready = 1'b1;
    drain();
    exp_q = '{16'h0400, 16'h0401, 16'h0402};
    check_order("bp", b);
    if (wlog.size() >= b + 3) begin
      chk("bp_stall_len", 128'(wstamp[b + 1] - wstamp[b]), 128'(4));
      chk("bp_resume", 128'(wstamp[b + 2] - wstamp[b + 1]), 128'(1));
    end

    // Reset while req1's packet is mid-flight
    b = wlog.size();
    db = dwho.size();
    push_pkt(1, 16'h0500, 128'hD0, 4);
    apply();
    wait_addr("rst_wait", 16'h0500);
    reset_n = 1'b0;
    step();
    chk("rst_WriteEnable", 128'(WriteEnable), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_req_done", 128'(req_done), 128'(0));
    push_pkt(0, 16'h0600, 128'hE0, 1);
    apply();
    step();
    reset_n = 1'b1;
    drain();
    exp_q = '{16'h0500, 16'h0600, 16'h0501, 16'h0502, 16'h0503};
    check_order("rst", b);
    chk("rst_done_count", 128'(dwho.size() - db), 128'(2));
    if (dwho.size() >= db + 2) begin
      chk("rst_done0", 128'(dwho[db]), 128'(0));
      chk("rst_done1", 128'(dwho[db + 1]), 128'(1));
    end

    // Competitor arrives while req0's packet holds the lock
    b = wlog.size();
    push_pkt(0, 16'h0700, 128'hF0, 3);
    apply();
    step();
    step();
    push_pkt(1, 16'h0800, 128'h80, 1);
    apply();
    #1;
    chk("lock_ready1", 128'(req_ready[1]), 128'(0));
    chk("lock_ready0", 128'(req_ready[0]), 128'(1));
    drain();
    exp_q = '{16'h0700, 16'h0701, 16'h0702, 16'h0800};
    check_order("lock", b);
    if (wlog.size() >= b + 4) chk("lock_bubble", 128'(wstamp[b + 3] - wstamp[b + 2]), 128'(2));

    // Total completed packets per requester
    c0 = 0;
    c1 = 0;
    foreach (dwho[i]) begin
      if (dwho[i] == 0) c0++;
      else c1++;
    end
    chk("done_total0", 128'(c0), 128'(6));
    chk("done_total1", 128'(c1), 128'(5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
